hazard_sequencer: RTL
=====================

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning max MEM_WAIT cycles without mem_ack before abort (range 2..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports id_valid  input  1, id_rn  input  4, id_rm  input  4, id_uses_rm  input  1  for the decode-stage instruction and its source registers.
REQ-005 SHALL have ports ex_valid  input  1, ex_is_load  input  1, ex_rd  input  4  for the execute-stage instruction.
REQ-006 SHALL have port branch_taken  input  1  meaning a branch resolved taken in EX this cycle.
REQ-007 SHALL have port mem_stage_op  input  1  meaning the MEM-stage instruction is a load or store.
REQ-008 SHALL have port mem_ack  input  1  meaning the data memory has completed the request.
REQ-009 SHALL have outputs pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_req (each 1 bit) as pipeline-register and memory controls.
REQ-010 SHALL have outputs mem_timeout  1  sticky error, stall_count  16  stall-cycle counter, state  2  current FSM state.

Function
REQ-011 SHALL implement states RUN=2'b00, LU_STALL=2'b01, MEM_WAIT=2'b10, FLUSH=2'b11; state output reflects the register.
REQ-012 SHALL define hazard = ex_valid & ex_is_load & id_valid & ex_rd!=4'hF & (id_rn==ex_rd | (id_uses_rm & id_rm==ex_rd)).
REQ-013 SHALL, in RUN, evaluate in priority mem_stage_op > branch_taken > hazard > none.
REQ-014 SHALL, in RUN with mem_stage_op: all enables 0, flush/bubble 0, mem_req 0; next MEM_WAIT.
REQ-015 SHALL, in RUN with branch_taken (no mem op): pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_en=1; next FLUSH.
REQ-016 SHALL, in RUN with hazard only: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=1; next LU_STALL.
REQ-017 SHALL, in RUN with none: pc_en=ifid_en=exmem_en=1, others 0; stay RUN.
REQ-018 SHALL, in LU_STALL: if mem_stage_op, behave as REQ-014 and go MEM_WAIT; else REQ-016 outputs and go RUN (two bubbles total per load-use).
REQ-019 SHALL, in FLUSH: pc_en=ifid_en=exmem_en=1, ifid_flush=1 (squash wrong-path fetch from 1-cycle instruction memory), idex_bubble=0; mem_stage_op and branch_taken ignored; next RUN unconditionally.
REQ-020 SHALL, in MEM_WAIT: mem_req=1; while mem_ack=0 all enables 0 and wait counter increments.
REQ-021 SHALL, in MEM_WAIT with mem_ack=1: pc_en=ifid_en=exmem_en=1 that same cycle, mem_req=1; next RUN; wait counter cleared.
REQ-022 SHALL, when wait counter reaches TIMEOUT-1 with mem_ack=0: set mem_timeout, apply REQ-021 outputs (operation dropped), next RUN.
REQ-023 SHALL keep mem_timeout set until reset; repeated timeouts have no further effect on it.
REQ-024 SHALL increment stall_count each cycle pc_en=0 and reset_n=1, saturating at 16'hFFFF.
REQ-025 SHALL hold mem_req stable high from MEM_WAIT entry until the ack/timeout cycle inclusive.

Reset
REQ-026 SHALL, on rising clk with reset_n=0, set state=RUN, wait counter=0, stall_count=0, mem_timeout=0, regardless of state (including mid-MEM_WAIT).
REQ-027 SHALL, while reset_n=0, force pc_en=ifid_en=exmem_en=0, mem_req=0, ifid_flush=1, idex_bubble=1 combinationally.

Verification
REQ-028 Load r3 in EX, ID reads id_rn=3 -> cycle 0 state RUN idex_bubble=1 pc_en=0; cycle 1 LU_STALL same outputs; cycle 2 RUN pc_en=1; stall_count=2.
REQ-029 Branch_taken in RUN -> cycle 0 ifid_flush=1 idex_bubble=1 pc_en=1; cycle 1 FLUSH ifid_flush=1 idex_bubble=0; cycle 2 RUN.
REQ-030 mem_stage_op=1, mem_ack after 3 wait cycles -> mem_req high 3 cycles plus ack cycle, enables 0 until ack cycle, then RUN; mem_timeout=0.
REQ-031 TIMEOUT=4, mem_ack never -> mem_timeout=1 after 4th MEM_WAIT cycle, enables 1 that cycle, RUN next; stays 1 through later clean accesses.
REQ-032 mem_stage_op, branch_taken and hazard together in RUN -> MEM_WAIT entered, no flush; after ack, branch flush occurs.
REQ-033 reset_n=0 during MEM_WAIT -> next edge state=RUN, mem_req=0, stall_count=0, mem_timeout=0.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: load-use stalls, taken-branch flushes and
// data-memory waits with a bounded timeout, plus a saturating stall counter.
module hazard_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic        id_uses_rm,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  input  logic        branch_taken,
  input  logic        mem_stage_op,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        mem_req,
  output logic        mem_timeout,
  output logic [15:0] stall_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    FLUSH    = 2'b11
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic hazard;
  logic pc_en_raw, ifid_en_raw, ifid_flush_raw, idex_bubble_raw, exmem_en_raw, mem_req_raw;

  // r15 is never a real destination, so it cannot create a load-use dependency
  assign hazard = ex_valid & ex_is_load & id_valid & (ex_rd != 4'hF) &
                  ((id_rn == ex_rd) | (id_uses_rm & (id_rm == ex_rd)));

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    mem_timeout_d   = mem_timeout_q;
    pc_en_raw       = 1'b0;
    ifid_en_raw     = 1'b0;
    ifid_flush_raw  = 1'b0;
    idex_bubble_raw = 1'b0;
    exmem_en_raw    = 1'b0;
    mem_req_raw     = 1'b0;

    case (state_q)
      RUN, LU_STALL: begin
        if (mem_stage_op) begin
          state_d = MEM_WAIT;
        end else if (state_q == RUN && branch_taken) begin
          pc_en_raw       = 1'b1;
          ifid_en_raw     = 1'b1;
          ifid_flush_raw  = 1'b1;
          idex_bubble_raw = 1'b1;
          exmem_en_raw    = 1'b1;
          state_d         = FLUSH;
        end else if (state_q == LU_STALL || hazard) begin
          // second bubble of a load-use pair is unconditional
          idex_bubble_raw = 1'b1;
          exmem_en_raw    = 1'b1;
          state_d         = (state_q == RUN) ? LU_STALL : RUN;
        end else begin
          pc_en_raw    = 1'b1;
          ifid_en_raw  = 1'b1;
          exmem_en_raw = 1'b1;
        end
      end
      FLUSH: begin
        pc_en_raw      = 1'b1;
        ifid_en_raw    = 1'b1;
        ifid_flush_raw = 1'b1;
        exmem_en_raw   = 1'b1;
        state_d        = RUN;
      end
      MEM_WAIT: begin
        mem_req_raw = 1'b1;
        if (mem_ack || wait_cnt_q == WAIT_LAST) begin
          pc_en_raw    = 1'b1;
          ifid_en_raw  = 1'b1;
          exmem_en_raw = 1'b1;
          wait_cnt_d   = 8'd0;
          state_d      = RUN;
          if (!mem_ack) mem_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase

    stall_count_d = stall_count_q;
    if (!pc_en_raw && stall_count_q != 16'hFFFF) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Reset freezes the pipeline and squashes IF/ID and ID/EX immediately
  assign pc_en       = reset_n & pc_en_raw;
  assign ifid_en     = reset_n & ifid_en_raw;
  assign exmem_en    = reset_n & exmem_en_raw;
  assign mem_req     = reset_n & mem_req_raw;
  assign ifid_flush  = ~reset_n | ifid_flush_raw;
  assign idex_bubble = ~reset_n | idex_bubble_raw;

  assign mem_timeout = mem_timeout_q;
  assign stall_count = stall_count_q;
  assign state       = state_q;

endmodule
